if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS datapath. Sits directly upstream of decode (control, register file, sign extend).
- Owns the program counter and issues word addresses to instruction memory over a req/ready handshake.
- Holds the IF/ID pipeline register (instruction, PC, PC+4, valid). Honours stall from the hazard unit and redirect (taken branch/jump, resolved downstream) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) loaded on flush/bubble

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held until imem_ready
- imem_addr  out  32  word address of outstanding request; stable while imem_req=1
- imem_rdata  in  32  instruction word; valid when imem_ready=1
- imem_ready  in  1  response strobe; may be asserted in the request's first cycle
- stall_i  in  1  hold IF/ID and PC (load-use hazard)
- redirect_i  in  1  discard in-flight fetch, flush IF/ID, restart at redirect_pc_i
- redirect_pc_i  in  32  branch/jump target; bits [1:0] forced to 0
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_instr_o  out  32  fetched instruction
- ifid_pc_o  out  32  address of ifid_instr_o
- ifid_pc4_o  out  32  ifid_pc_o + 4; feeds branch adder and jump concatenation

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE; pc_q=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - ifid_valid_o=0; ifid_instr_o=NOP_INSTR; ifid_pc_o=0; ifid_pc4_o=0.
- States: IDLE, FETCH, HOLD, DROP.
  - IDLE: imem_req=0. Next cycle -> FETCH. Single cycle after reset release.
  - FETCH: imem_req=1, imem_addr=req_addr_q (= pc_q at issue).
  - HOLD: response received under stall and kept in a one-entry buffer. imem_req=0.
  - DROP: request still outstanding but its result is unwanted. imem_req=1, same address held. On imem_ready, data is discarded -> FETCH at pc_q.
- FETCH transitions (priority redirect > stall):
  - redirect_i & imem_ready -> pc_q=redirect_pc, stay FETCH. New address is presented the next cycle.
  - redirect_i & !imem_ready -> pc_q=redirect_pc, -> DROP.
  - imem_ready & !stall_i -> IF/ID loads {1, rdata, pc_q, pc_q+4}; pc_q += 4; stay FETCH. Back-to-back issue gives 1 instr/cycle with a zero-wait memory.
  - imem_ready & stall_i -> buffer {rdata, pc_q}; IF/ID held; -> HOLD.
  - !imem_ready & !stall_i -> IF/ID loads bubble (valid=0, NOP_INSTR).
  - !imem_ready & stall_i -> IF/ID held.
- HOLD transitions:
  - redirect_i -> buffer invalidated, pc_q=redirect_pc, -> FETCH.
  - !stall_i -> IF/ID loads buffer; pc_q += 4; -> FETCH.
  - Else remain in HOLD.
- Redirect in any state: IF/ID is flushed that edge (valid=0, instr=NOP_INSTR), overriding stall_i. A redirect arriving in DROP updates pc_q only.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Latency: fetch-to-IF/ID = memory wait cycles + 1 edge. Redirect-to-first-valid IF/ID = 2 cycles with a zero-wait memory.
- Reset mid-request: request is abandoned (imem_req drops asynchronously). Instruction memory must accept an abandoned request.
- imem_addr must never change while imem_req=1 and imem_ready=0 (checked by assertion).

Decomposition:
- Shared package pipe_pkg:
  - fetch state enum {IDLE, FETCH, HOLD, DROP}
  - NOP_INSTR
  - default RESET_PC
  - IF/ID bundle typedef (valid, instr, pc, pc4), reused by later pipeline registers
- One sub-module: ifid_reg. Generic pipeline register with load, hold and flush inputs and async active-low reset. Reused for ID/EX, EX/MEM and MEM/WB.

Test Plan:
- Reset release, zero-wait memory (imem_ready tied 1) -> imem_addr sequence 0,4,8,12. IF/ID valid from cycle 2, ifid_pc4_o = ifid_pc_o+4.
- 2-wait memory (ready every 3rd cycle), no stall -> IF/ID shows valid, bubble, bubble, valid. PC advances by 4 only on ready.
- stall_i high 3 cycles as ready arrives at addr 0x10 -> state HOLD, IF/ID unchanged. After release, IF/ID instr from 0x10, next fetch 0x14, no instruction lost or duplicated.
- redirect_i to 0x0000_0103 while request at 0x20 is pending (no ready) -> DROP, addr 0x20 held until ready, data discarded. Next fetch 0x100, IF/ID flushed to NOP with valid=0.
- redirect_i and stall_i in the same cycle -> flush wins: ifid_valid_o=0, next fetch at redirect target.
- pc_q=0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000. rst_n asserted mid-wait -> imem_req=0 immediately, outputs at reset values, restart at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MIPS datapath: fetch FSM states, bubble encoding
// and the IF/ID bundle that later pipeline registers reuse.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: flush beats hold, hold beats load.
// Shared by IF/ID, ID/EX, EX/MEM and MEM/WB through the type parameter.
module ifid_reg
  import pipe_pkg::*;
#(
  parameter type T         = ifid_t,
  parameter T    RESET_VAL = '0,
  parameter T    FLUSH_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic hold,
  input  logic flush,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (flush) begin
      q <= FLUSH_VAL;
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory and
// fills the IF/ID register, honouring hazard stalls and downstream redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_ready,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   ifid_valid_o,
  output logic [31:0]            ifid_instr_o,
  output logic [31:0]            ifid_pc_o,
  output logic [31:0]            ifid_pc4_o,
  output pipe_pkg::fetch_state_e dbg_state
);
  import pipe_pkg::*;

  // Handshake: imem_req stays high with imem_addr frozen until the cycle in
  // which imem_ready is seen high; that cycle completes the transfer and
  // imem_rdata is consumed (or discarded in DROP) at the same clock edge.

  localparam ifid_t IFID_EMPTY = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, req_addr_q, redirect_pc;
  logic [31:0]  buf_instr_q, buf_pc_q;
  logic         buf_load, ifid_load, ifid_flush;
  ifid_t        ifid_d, ifid_q;

  assign redirect_pc = redirect_pc_i & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // A new request is issued whenever the next state is FETCH; DROP keeps the old address.
      if (state_d == FETCH) req_addr_q <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0;
    end else if (buf_load) begin
      buf_instr_q <= imem_rdata;
      buf_pc_q    <= req_addr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_load   = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{valid: 1'b1, instr: imem_rdata, pc: req_addr_q, pc4: pc_plus4(req_addr_q)};
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_i) begin
          state_d = imem_ready ? FETCH : DROP;
        end else if (imem_ready && !stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4(pc_q);
        end else if (imem_ready) begin
          buf_load = 1'b1;
          state_d  = HOLD;
        end else if (!stall_i) begin
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          state_d = FETCH;
        end else if (!stall_i) begin
          ifid_d    = '{valid: 1'b1, instr: buf_instr_q, pc: buf_pc_q, pc4: pc_plus4(buf_pc_q)};
          ifid_load = 1'b1;
          pc_d      = pc_plus4(pc_q);
          state_d   = FETCH;
        end
      end
      DROP: begin
        if (imem_ready) state_d = FETCH;
      end
    endcase
    // Redirect overrides everything, including a stall.
    if (redirect_i) begin
      pc_d       = redirect_pc;
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  ifid_reg #(
    .T        (ifid_t),
    .RESET_VAL(IFID_EMPTY),
    .FLUSH_VAL(IFID_EMPTY)
  ) u_ifid_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ifid_load),
    .hold (stall_i),
    .flush(ifid_flush),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign imem_req     = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr    = req_addr_q;
  assign ifid_valid_o = ifid_q.valid;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_pc4_o   = ifid_q.pc4;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: wait-state memory model, expected-PC scoreboard
// and directed phases for stall, redirect, wrap-around and reset mid-request.
module tb_if_fetch_stage;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_ready;
  logic         stall_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         ifid_valid_o;
  logic [31:0]  ifid_instr_o;
  logic [31:0]  ifid_pc_o;
  logic [31:0]  ifid_pc4_o;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wait   = 0;
  int wait_ctr = 0;

  logic [31:0] exp_q[$];
  logic        drop_pend = 1'b0;
  logic        pre_rst, pre_req, pre_rdy, pre_stall, pre_rdr;
  logic [31:0] pre_addr, exp_pc;
  bit          exp_v[4];
  logic [31:0] exp_a[4];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .dbg_state    (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2408_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model: n_wait idle cycles before each ready ----------------
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    #2;
    if (!rst_n || !imem_req) begin
      wait_ctr   = 0;
      imem_ready = 1'b0;
    end else if (wait_ctr >= n_wait) begin
      imem_ready = 1'b1;
      wait_ctr   = 0;
    end else begin
      imem_ready = 1'b0;
      wait_ctr++;
    end
  end

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    pre_rst   = rst_n;
    pre_req   = imem_req;
    pre_rdy   = imem_ready;
    pre_stall = stall_i;
    pre_rdr   = redirect_i;
    pre_addr  = imem_addr;
    if (!rst_n) begin
      exp_q.delete();
      drop_pend = 1'b0;
    end else if (pre_req && pre_rdy) begin
      if (!pre_rdr && !drop_pend) exp_q.push_back(pre_addr);
      drop_pend = 1'b0;
    end else if (pre_req && pre_rdr) begin
      drop_pend = 1'b1;
    end
    #1;
    if (pre_rst && rst_n) begin
      if (pre_req && !pre_rdy) check("addr_stable", imem_addr, pre_addr);
      if (pre_rdr) begin
        check("flush_valid", 32'(ifid_valid_o), 32'd0);
        check("flush_instr", ifid_instr_o, NOP_INSTR);
      end else if (!pre_stall && ifid_valid_o) begin
        exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : ~ifid_pc_o;
        check("sb_pc", ifid_pc_o, exp_pc);
        check("sb_instr", ifid_instr_o, mem_word(exp_pc));
        check("sb_pc4", ifid_pc4_o, exp_pc + 32'd4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_addr(input logic [31:0] a, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (imem_req && imem_addr == a) break;
      @(negedge clk);
    end
    check(tag, imem_req ? imem_addr : ~a, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(ifid_valid_o), 32'd0);
    check({tag, "_instr"}, ifid_instr_o, NOP_INSTR);
    check({tag, "_pc"}, ifid_pc_o, 32'h0);
    check({tag, "_pc4"}, ifid_pc4_o, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed phases ----------------
  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Zero-wait memory: addresses 0,4,8,12, IF/ID valid from the second edge.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zw_addr", imem_addr, 32'(i * 4));
      check("zw_req", 32'(imem_req), 32'd1);
      if (i == 0) check("zw_valid_c1", 32'(ifid_valid_o), 32'd0);
      if (i == 1) check("zw_valid_c2", 32'(ifid_valid_o), 32'd1);
    end

    // Two-wait memory from reset: valid, bubble, bubble, valid.
    rst_n  = 1'b0;
    n_wait = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_v = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_a = '{32'h4, 32'h4, 32'h4, 32'h8};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w2_valid", 32'(ifid_valid_o), 32'(exp_v[i]));
      check("w2_addr", imem_addr, exp_a[i]);
    end

    // Stall for three cycles as the response for 0x10 arrives.
    n_wait = 0;
    wait_addr(32'h10, "stall_wait");
    check("pre_stall_pc", ifid_pc_o, 32'hC);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_state", 32'(dbg_state), 32'(HOLD));
      check("hold_pc", ifid_pc_o, 32'hC);
      check("hold_valid", 32'(ifid_valid_o), 32'd1);
      check("hold_req", 32'(imem_req), 32'd0);
    end
    stall_i = 1'b0;
    @(negedge clk);
    check("release_pc", ifid_pc_o, 32'h10);
    check("release_instr", ifid_instr_o, mem_word(32'h10));
    check("release_addr", imem_addr, 32'h14);
    check("release_state", 32'(dbg_state), 32'(FETCH));

    // Redirect while the request at 0x20 is still waiting.
    n_wait = 4;
    wait_addr(32'h20, "drop_wait");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    redirect_i = 1'b0;
    check("drop_state", 32'(dbg_state), 32'(DROP));
    check("drop_addr", imem_addr, 32'h20);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_valid", 32'(ifid_valid_o), 32'd0);
    wait_addr(32'h100, "redirect_target");
    check("after_drop_state", 32'(dbg_state), 32'(FETCH));
    n_wait = 0;

    // Redirect and stall together: the flush wins.
    wait_addr(32'h108, "rs_wait");
    redirect_i    = 1'b1;
    stall_i       = 1'b1;
    redirect_pc_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    check("rs_valid", 32'(ifid_valid_o), 32'd0);
    check("rs_instr", ifid_instr_o, NOP_INSTR);
    check("rs_addr", imem_addr, 32'h200);

    // PC wrap-around at the top of the address space.
    wait_addr(32'h208, "wrap_sync");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_addr(32'hFFFF_FFFC, "wrap_wait");
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", ifid_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", ifid_pc4_o, 32'h0);

    // Reset while a request is waiting on memory.
    n_wait = 4;
    wait_addr(32'h8, "rst_wait");
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    n_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_addr0", imem_addr, 32'h0);
    check("restart_state", 32'(dbg_state), 32'(FETCH));
    @(negedge clk);
    check("restart_addr1", imem_addr, 32'h4);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
